// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the IF/MEM stages, the arbiter and the unified memory.
// slave: arbiter view; master: pipeline + memory model view.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifReq;
   logic [ADDR_W-1:0] ifAddr;
   logic              dmRead;
   logic              dmWrite;
   logic [ADDR_W-1:0] dmAddr;
   logic [DATA_W-1:0] dmWdata;
   logic [DATA_W-1:0] memRdata;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic              memRead;
   logic              memWrite;
   logic [DATA_W-1:0] ifRdata;
   logic              ifValid;
   logic [DATA_W-1:0] dmRdata;
   logic              dmDone;
   logic              stallFetch;
   logic              stallPipe;

   modport slave (
      input  ifReq, ifAddr, dmRead, dmWrite, dmAddr, dmWdata,
      input  memRdata,
      output memAddr, memWdata, memRead, memWrite,
      output ifRdata, ifValid, dmRdata, dmDone,
      output stallFetch, stallPipe
   );

   modport master (
      output ifReq, ifAddr, dmRead, dmWrite, dmAddr, dmWdata,
      output memRdata,
      input  memAddr, memWdata, memRead, memWrite,
      input  ifRdata, ifValid, dmRdata, dmDone,
      input  stallFetch, stallPipe
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one unified memory between fetch and MEM.
// Ports: clk, rst (sync, active high), bus (slave modport, all data/strobes).
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   unified_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

   localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic              lastDm;
   logic              grantDm;
   logic              dmReq;
   logic              pickDm;
   logic              pickWr;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] wdNext;

   assign dmReq = bus.dmRead | bus.dmWrite;

   // DM wins when alone, or on a tie when IF was served last.
   assign pickDm = dmReq & (~bus.ifReq | ~lastDm);

   // Read+write together is a store.
   assign pickWr = pickDm & bus.dmWrite;

   always_comb begin
      addrNext = bus.ifAddr;
      wdNext   = '0;
      if (pickDm) addrNext = bus.dmAddr;
      if (pickWr) wdNext = bus.dmWdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         lastDm       <= 1'b0;
         grantDm      <= 1'b0;
         bus.memAddr  <= '0;
         bus.memWdata <= '0;
         bus.memRead  <= 1'b0;
         bus.memWrite <= 1'b0;
         bus.ifRdata  <= '0;
         bus.ifValid  <= 1'b0;
         bus.dmRdata  <= '0;
         bus.dmDone   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dmReq | bus.ifReq) begin
                  grantDm      <= pickDm;
                  lastDm       <= pickDm;
                  bus.memAddr  <= addrNext;
                  bus.memWdata <= wdNext;
                  bus.memRead  <= ~pickWr;
                  bus.memWrite <= pickWr;
                  cnt          <= '0;
                  state        <= ACC;
               end
            end
            ACC: begin
               if (cnt == CNT_LAST) begin
                  if (!grantDm)
                     bus.ifRdata <= bus.memRdata;
                  else if (bus.memRead)
                     bus.dmRdata <= bus.memRdata;
                  bus.memAddr  <= '0;
                  bus.memWdata <= '0;
                  bus.memRead  <= 1'b0;
                  bus.memWrite <= 1'b0;
                  bus.ifValid  <= ~grantDm;
                  bus.dmDone   <= grantDm;
                  state        <= RSP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RSP: begin
               bus.ifValid <= 1'b0;
               bus.dmDone  <= 1'b0;
               cnt         <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stalls are masked while reset is held so every output reads 0.
   assign bus.stallPipe  = ~rst & dmReq & ~bus.dmDone;
   assign bus.stallFetch = ~rst & ((bus.ifReq & ~bus.ifValid)
                                   | (dmReq & ~bus.dmDone));

endmodule
